dice_input_conditioner: RTL

Front end of the dice roller. Synchronizes and debounces the six raw die-select push buttons (D4, D6, D8, D10, D12, D20) and converts each clean press into a single roll request carrying the die size. The request goes to the roll engine over a valid/ready handshake. A test switch shortens the debounce window so benches and bring-up do not need millisecond-scale waits.

---
 rtl/dice_pkg.sv | 41 ++++
 rtl/debounce_channel.sv | 66 ++++++
 rtl/dice_input_conditioner.sv | 129 ++++++++++++
 3 files changed

// File: rtl/dice_pkg.sv
// Shared constants for the dice roller front end: button indices, die sizes and
// the roll-request FSM state type.
package dice_pkg;

   localparam int unsigned NUM_BTN = 6;

   localparam int unsigned BTN_D4  = 0;
   localparam int unsigned BTN_D6  = 1;
   localparam int unsigned BTN_D8  = 2;
   localparam int unsigned BTN_D10 = 3;
   localparam int unsigned BTN_D12 = 4;
   localparam int unsigned BTN_D20 = 5;

   localparam logic [4:0] DIE_D4  = 5'd4;
   localparam logic [4:0] DIE_D6  = 5'd6;
   localparam logic [4:0] DIE_D8  = 5'd8;
   localparam logic [4:0] DIE_D10 = 5'd10;
   localparam logic [4:0] DIE_D12 = 5'd12;
   localparam logic [4:0] DIE_D20 = 5'd20;

   typedef enum logic [0:0] {
      StIdle,
      StPending
   } reqState_e;

   // Die size for a button index; unknown indices map to 0 (no die).
   function automatic logic [4:0] dieSides(input int idx);
      logic [4:0] sides;
      case (idx)
         0:       sides = DIE_D4;
         1:       sides = DIE_D6;
         2:       sides = DIE_D8;
         3:       sides = DIE_D10;
         4:       sides = DIE_D12;
         5:       sides = DIE_D20;
         default: sides = 5'd0;
      endcase
      return sides;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchronizer, consecutive-disagreement counter and
// debounced level register with a one-cycle rising-edge pulse.
module debounce_channel #(
   parameter int unsigned DEBOUNCE_CYCLES      = 1_000_000,
   parameter int unsigned TEST_DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   input  logic useTest,
   input  logic clrCnt,
   output logic level,
   output logic rise
);

   localparam int unsigned MaxCycles = (DEBOUNCE_CYCLES > TEST_DEBOUNCE_CYCLES) ?
                                       DEBOUNCE_CYCLES : TEST_DEBOUNCE_CYCLES;
   localparam int unsigned CntW = $clog2(MaxCycles + 1);

   // The counter holds disagreements already seen, so the toggle fires on the
   // cycle that would bring it to the limit.
   localparam logic [CntW-1:0] NormLast = CntW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CntW-1:0] TestLast = CntW'(TEST_DEBOUNCE_CYCLES - 1);

   logic            syncMetaQ, syncQ;
   logic [CntW-1:0] cntQ, cntD;
   logic            levelQ, levelD;
   logic            riseQ, riseD;
   logic [CntW-1:0] lastCnt;

   always_comb begin
      lastCnt = useTest ? TestLast : NormLast;
      cntD    = cntQ;
      levelD  = levelQ;
      riseD   = 1'b0;
      if (clrCnt || (syncQ == levelQ)) begin
         cntD = '0;
      end else if (cntQ >= lastCnt) begin
         levelD = ~levelQ;
         riseD  = ~levelQ;
         cntD   = '0;
      end else begin
         cntD = cntQ + CntW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         syncMetaQ <= 1'b0;
         syncQ     <= 1'b0;
         cntQ      <= '0;
         levelQ    <= 1'b0;
         riseQ     <= 1'b0;
      end else begin
         syncMetaQ <= raw;
         syncQ     <= syncMetaQ;
         cntQ      <= cntD;
         levelQ    <= levelD;
         riseQ     <= riseD;
      end
   end

   assign level = levelQ;
   assign rise  = riseQ;

endmodule

// File: rtl/dice_input_conditioner.sv
// Dice roller front end: debounces six die-select buttons and turns each clean
// press into one valid/ready roll request carrying the die size.
module dice_input_conditioner
   import dice_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES      = 1_000_000,
   parameter int unsigned TEST_DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_d4,
   input  logic       btn_d6,
   input  logic       btn_d8,
   input  logic       btn_d10,
   input  logic       btn_d12,
   input  logic       btn_d20,
   input  logic       switch_test,
   output logic [5:0] btn_level,
   output logic       roll_valid,
   output logic [4:0] roll_sides,
   input  logic       roll_ready,
   output logic       press_dropped
);

   logic               swMetaQ, swSyncQ, swPrevQ;
   logic               modeChange;
   logic [NUM_BTN-1:0] rawBtn;
   logic [NUM_BTN-1:0] level;
   logic [NUM_BTN-1:0] rise;
   logic [4:0]         winSides;
   logic               multiRise;

   reqState_e  stateQ, stateD;
   logic [4:0] sidesQ, sidesD;
   logic       droppedQ, droppedD;

   always_comb begin
      rawBtn          = '0;
      rawBtn[BTN_D4]  = btn_d4;
      rawBtn[BTN_D6]  = btn_d6;
      rawBtn[BTN_D8]  = btn_d8;
      rawBtn[BTN_D10] = btn_d10;
      rawBtn[BTN_D12] = btn_d12;
      rawBtn[BTN_D20] = btn_d20;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         swMetaQ <= 1'b0;
         swSyncQ <= 1'b0;
         swPrevQ <= 1'b0;
      end else begin
         swMetaQ <= switch_test;
         swSyncQ <= swMetaQ;
         swPrevQ <= swSyncQ;
      end
   end

   // Changing the window mid-count would mix two limits, so every count restarts.
   assign modeChange = swSyncQ ^ swPrevQ;

   for (genvar i = 0; i < NUM_BTN; i++) begin : gChan
      debounce_channel #(
         .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
         .TEST_DEBOUNCE_CYCLES (TEST_DEBOUNCE_CYCLES)
      ) uChan (
         .clk     (clk),
         .reset   (reset),
         .raw     (rawBtn[i]),
         .useTest (swSyncQ),
         .clrCnt  (modeChange),
         .level   (level[i]),
         .rise    (rise[i])
      );
   end

   // Higher index is the larger die and wins, so the last match overrides.
   always_comb begin
      winSides = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         if (rise[i]) winSides = dieSides(i);
      end
      multiRise = (rise & (rise - NUM_BTN'(1))) != '0;
   end

   always_comb begin
      stateD   = stateQ;
      sidesD   = sidesQ;
      droppedD = droppedQ;
      unique case (stateQ)
         StIdle: begin
            if (|rise) begin
               stateD = StPending;
               sidesD = winSides;
               if (multiRise) droppedD = 1'b1;
            end
         end
         StPending: begin
            if (|rise) droppedD = 1'b1;
            if (roll_ready) begin
               stateD = StIdle;
               sidesD = '0;
            end
         end
         default: begin
            stateD = StIdle;
            sidesD = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stateQ   <= StIdle;
         sidesQ   <= '0;
         droppedQ <= 1'b0;
      end else begin
         stateQ   <= stateD;
         sidesQ   <= sidesD;
         droppedQ <= droppedD;
      end
   end

   assign btn_level     = level;
   assign roll_valid    = (stateQ == StPending);
   assign roll_sides    = sidesQ;
   assign press_dropped = droppedQ;

endmodule
